// File: rtl/seq_detect_param.sv
// Parametrised serial pattern recognizer: Mealy match on the last N enabled samples against a
// runtime-loadable pattern, with optional non-overlapping search and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w,
  input  logic          en,
  input  logic          pat_load,
  input  logic [N-1:0]  pat_in,
  input  logic          clr_count,
  output logic          out,
  output logic [CW-1:0] count,
  output logic          armed
);

  localparam int unsigned FW = $clog2(N);
  localparam logic [FW-1:0] FillMax = FW'(N - 1);

  logic [N-1:0]  pat_q, pat_d;
  logic [N-2:0]  hist_q, hist_d, hist_shift;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic          match;

  // A 2-bit pattern keeps a single history bit, so there is nothing older to shift along.
  generate
    if (N == 2) begin : g_hist_one
      assign hist_shift = w;
    end else begin : g_hist_many
      assign hist_shift = {hist_q[N-3:0], w};
    end
  endgenerate

  assign armed = (fill_q == FillMax);
  assign match = en & ~pat_load & armed & ({hist_q, w} == pat_q);
  assign out   = match;
  assign count = count_q;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      if (match && !OVERLAP) begin
        // Restart the search; stale bits in hist are ignored until fill reaches N-1 again.
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (match && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, non-overlap, 2-bit counter) share one
// stimulus stream and are checked against a string-based model of the recent sample history.
module tb_seq_detect_param;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset, w, en, pat_load, clr_count;
  logic [3:0] pat_in;
  logic [2:0] outs, arms;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model: valid history as a string of '0'/'1' (oldest first), pattern as a string.
  string hs[3];
  int    cnt[3];
  string patstr;
  bit    ov[3]   = '{1'b1, 1'b0, 1'b1};
  int    cmax[3] = '{255, 255, 3};

  always #5 clk = ~clk;

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .w(w), .en(en), .pat_load(pat_load), .pat_in(pat_in),
    .clr_count(clr_count), .out(outs[0]), .count(cnt_a), .armed(arms[0])
  );

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CW(8)) dut_b (
    .clk(clk), .reset(reset), .w(w), .en(en), .pat_load(pat_load), .pat_in(pat_in),
    .clr_count(clr_count), .out(outs[1]), .count(cnt_b), .armed(arms[1])
  );

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(2)) dut_c (
    .clk(clk), .reset(reset), .w(w), .en(en), .pat_load(pat_load), .pat_in(pat_in),
    .clr_count(clr_count), .out(outs[2]), .count(cnt_c), .armed(arms[2])
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic string to_str(input logic [3:0] p);
    string s = "";
    for (int i = 3; i >= 0; i--) s = {s, (p[i] ? "1" : "0")};
    return s;
  endfunction

  function automatic int dut_count(input int k);
    case (k)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hs[k]  = "";
      cnt[k] = 0;
    end
    patstr = to_str(4'b1101);
  endtask

  // Drive one cycle, check outputs before the edge, then advance model and clock.
  task automatic step(input logic r, input logic e, input logic wv, input logic pl,
                      input logic [3:0] pi, input logic cl);
    string wc;
    bit    m_arm, m_out;
    reset = r; en = e; w = wv; pat_load = pl; pat_in = pi; clr_count = cl;
    #1;
    wc = wv ? "1" : "0";
    for (int k = 0; k < 3; k++) begin
      m_arm = (hs[k].len() == N - 1);
      m_out = e && !pl && m_arm && ({hs[k], wc} == patstr);
      check_eq($sformatf("%s_armed%0d", phase, k), int'(arms[k]), int'(m_arm));
      check_eq($sformatf("%s_count%0d", phase, k), dut_count(k), cnt[k]);
      check_eq($sformatf("%s_out%0d", phase, k), int'(outs[k]), int'(m_out));
      if (cl) cnt[k] = 0;
      else if (m_out && cnt[k] < cmax[k]) cnt[k]++;
      if (pl) begin
        hs[k] = "";
      end else if (e) begin
        if (m_out && !ov[k]) begin
          hs[k] = "";
        end else begin
          hs[k] = {hs[k], wc};
          if (hs[k].len() > N - 1) hs[k] = hs[k].substr(hs[k].len() - (N - 1), hs[k].len() - 1);
        end
      end
    end
    if (pl) patstr = to_str(pi);
    if (r) model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input string bits);
    for (int i = 0; i < bits.len(); i++) step(1'b0, 1'b1, bits[i] == "1", 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; w = 1'b0; pat_load = 1'b0; pat_in = 4'h0; clr_count = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    phase = "t1";
    do_reset();
    feed("0000110111110000110");
    feed("1");
    check_eq("t1_final_count", int'(cnt_a), 2);

    phase = "t2";
    do_reset();
    feed("1101101");
    check_eq("t2_overlap_count", int'(cnt_a), 2);
    check_eq("t2_nonoverlap_count", int'(cnt_b), 1);

    phase = "t3";
    do_reset();
    feed("11");
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    feed("01");
    check_eq("t3_gap_count", int'(cnt_a), 1);

    phase = "t4";
    do_reset();
    feed("10");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    feed("0110110");
    check_eq("t4_load_count", int'(cnt_a), 2);

    phase = "t5";
    do_reset();
    feed("1101101101101101");
    check_eq("t5_sat_count", int'(cnt_c), 3);
    feed("10");
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    check_eq("t5_clr_count", int'(cnt_c), 0);

    phase = "t6";
    do_reset();
    feed("110");
    do_reset();
    check_eq("t6_armed", int'(arms[0]), 0);
    check_eq("t6_count", int'(cnt_a), 0);
    feed("1");
    feed("1101");
    check_eq("t6_final_count", int'(cnt_a), 1);

    phase = "rnd";
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 49) == 0, 4'($urandom), $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
